dts_result_checker: RTL and testbench
=====================================

Name: dts_result_checker

Overview:
- Downstream consumer of the DTS search worker. Watches the worker's done flag and captures its natRuler output.
- Independently re-verifies the captured result as a legal difference triangle set: mark counts per block, plus all pairwise differences distinct across every block.
- Streams verified marks out over a valid/ready interface, then pulses the worker's synchronous reset so the search restarts.
- Failed results are counted and dropped.

Parameters:
- n, 3, number of blocks
- k, 3, marks per block excluding the zero mark
- M, 19, largest mark value considered
- n_iWIDTH, 2, bits to index n blocks
- M_WIDTH, 5, bits to represent 0..M
- RST_CYCLES, 4, cycles workerReset is held high per restart (>=1)
- CNT_WIDTH, 16, width of the result and error counters

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- natRuler  in  n*(M+1)  worker ruler bitmaps; block b occupies bits [M+b*(M+1) : b*(M+1)], bit p set = mark at p
- done  in  1  worker finished; natRuler stable while high
- workerReset  out  1  synchronous reset driven to the worker
- outValid  out  1  outMark/outBlock valid
- outReady  in  1  consumer accepts when outValid&&outReady at posedge
- outMark  out  M_WIDTH  mark value
- outBlock  out  n_iWIDTH  block index of outMark
- outLast  out  1  final mark of the result
- resultCount  out  CNT_WIDTH  results fully emitted
- errCount  out  CNT_WIDTH  results failing verification

Behaviour:
- Reset (asynchronous, active-high):
  - state=RESTART, restart counter=0, workerReset=1.
  - outValid=0, outMark=0, outBlock=0, outLast=0.
  - resultCount=0, errCount=0, captured ruler=0.
- States: RESTART, IDLE, CHECK, EMIT.
- RESTART:
  - workerReset=1 for exactly RST_CYCLES cycles, counted from entry.
  - Then go to IDLE with workerReset=0. workerReset is registered and low in every other state.
- IDLE:
  - When done=1 at a posedge: latch natRuler into an internal register, clear the accumulated spectrum (M+1 bits), clear the fail flag, set b=0, p=0, mark count=0, then go to CHECK.
  - done is ignored outside IDLE.
- CHECK (one cycle per (b,p); b outer, p inner; exactly n*(M+1) cycles):
  - If bit p of block b is set: mark count+1. Let d = (block b >> p) with bit 0 cleared. If d & spectrum != 0, set fail. Else spectrum |= d.
  - Intra-block duplicates are caught the same way because spectrum is updated per mark.
  - At p=M: fail if bit 0 of block b is clear, or if mark count (including the zero mark) != k+1. Then reset mark count, p=0, b+1.
  - After the last (b=n-1, p=M):
    - fail set: errCount+1 (wraps), go to RESTART.
    - otherwise: b=0, p=0, go to EMIT.
- EMIT (scan b outer, p inner):
  - Position bit clear: advance one cycle with outValid=0.
  - Position bit set: outValid=1, outMark=p, outBlock=b, outLast=1 iff no set bit remains in later positions.
  - Outputs are held stable until outValid&&outReady. outValid is never withdrawn before acceptance.
  - On acceptance: advance; outValid may drop for skipped positions.
  - On acceptance with outLast: resultCount+1 (wraps), outValid=0, go to RESTART.
- Arithmetic: shifts are logical. Counters wrap modulo 2^CNT_WIDTH. Scan indices never exceed n-1 / M.
- Reset mid-CHECK or mid-EMIT: partial result discarded, counters cleared, worker restarted.
- outReady held low indefinitely: block stalls in EMIT; the worker stays done, unchanged and unreset.

Test Plan (n=2, k=2, M=9, n_iWIDTH=1, M_WIDTH=4, RST_CYCLES=4):
- Reset then release -> workerReset high for 4 cycles after release, then low; outValid=0, both counters 0.
- Valid result: block0={0,1,3} (0x00B), block1={0,4,9} (0x211), done=1, outReady=1:
  - After 20 CHECK cycles, emits (mark,block) = (0,0),(1,0),(3,0),(0,1),(4,1),(9,1).
  - outLast only on (9,1); resultCount=1; then workerReset pulses for 4 cycles.
- Difference collision: block1={0,2,5} (diff 2 collides with block0 diff 2) -> no outValid, errCount=1, workerReset pulse.
- Wrong mark count: block1={0,4} -> errCount=1, no emission. Missing zero mark: block1={4,6,9} -> errCount=1.
- Backpressure on the valid result: outReady=0 for 5 cycles on (3,0) -> outMark=3, outBlock=0, outValid=1 held all 5 cycles; the sequence then continues unchanged.
- Async reset asserted mid-EMIT after 2 accepted marks -> outputs return immediately to reset values; resultCount stays 0; a fresh workerReset pulse follows release.

Source files
------------

// File: rtl/dts_result_checker.sv
// dts_result_checker
// Takes the result from a DTS search worker when it finishes and checks it
// again from scratch. A result is a legal difference triangle set if every
// block holds the zero mark plus exactly k further marks, and no pairwise
// difference appears twice, within a block or across blocks. A legal result
// is streamed out one mark at a time. Whatever the outcome, the worker then
// gets a reset pulse so that it starts a new search.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   natRuler     worker ruler bitmaps, block b at [b*(M+1) +: M+1]
//   done         worker finished; natRuler is stable while high
//   workerReset  registered synchronous reset to the worker
//   outValid     outMark/outBlock valid
//   outReady     consumer accepts when outValid && outReady at posedge
//   outMark      mark value
//   outBlock     block index of outMark
//   outLast      final mark of the result
//   resultCount  results fully emitted (wraps)
//   errCount     results that failed the check (wraps)
//
// state   | meaning
// --------+---------------------------------------------------------------
// RESTART | workerReset held high for RST_CYCLES cycles
// IDLE    | waiting for done; latch the ruler when it arrives
// CHECK   | one cycle per (block, position); builds the difference spectrum
// EMIT    | streams the marks out, stalling on outReady

module dts_result_checker #(
    parameter int n          = 3,
    parameter int k          = 3,
    parameter int M          = 19,
    parameter int n_iWIDTH   = 2,
    parameter int M_WIDTH    = 5,
    parameter int RST_CYCLES = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [n*(M+1)-1:0]    natRuler,
    input  logic                  done,
    output logic                  workerReset,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [M_WIDTH-1:0]    outMark,
    output logic [n_iWIDTH-1:0]   outBlock,
    output logic                  outLast,
    output logic [CNT_WIDTH-1:0]  resultCount,
    output logic [CNT_WIDTH-1:0]  errCount
);

    localparam int W    = M + 1;
    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam int MC_W = M_WIDTH + 1;

    typedef enum logic [1:0] {RESTART, IDLE, CHECK, EMIT} state_t;

    state_t                state_q, state_d;
    logic [RC_W-1:0]       rst_cnt_q, rst_cnt_d;
    logic                  worker_reset_q, worker_reset_d;
    logic [n*W-1:0]        ruler_q, ruler_d;
    logic [W-1:0]          spectrum_q, spectrum_d;
    logic                  fail_q, fail_d;
    logic [n_iWIDTH-1:0]   b_q, b_d;
    logic [M_WIDTH-1:0]    p_q, p_d;
    logic [MC_W-1:0]       mark_cnt_q, mark_cnt_d;
    logic [CNT_WIDTH-1:0]  result_cnt_q, result_cnt_d;
    logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;

    logic [W-1:0]          blocks [n];
    logic [W-1:0]          blk;
    logic                  cur_bit;
    logic [W-1:0]          diff;
    logic [MC_W-1:0]       mark_cnt_inc;
    logic                  later_clear;

    // Datapath around the current scan position (b_q, p_q).
    always_comb begin
        for (int i = 0; i < n; i++) begin
            blocks[i] = ruler_q[i*W +: W];
        end
        blk     = blocks[b_q];
        cur_bit = blk[p_q];
        // Differences from the mark at p to every larger mark in this block.
        diff    = blk >> p_q;
        diff[0] = 1'b0;
        mark_cnt_inc = mark_cnt_q + MC_W'(cur_bit);
        // outLast: no set bit in any later position of the whole ruler.
        later_clear = 1'b1;
        for (int i = 0; i < n; i++) begin
            if ((n_iWIDTH'(i) > b_q) && (blocks[i] != '0)) begin
                later_clear = 1'b0;
            end
        end
        if (((blk >> p_q) >> 1) != '0) begin
            later_clear = 1'b0;
        end
    end

    always_comb begin
        state_d        = state_q;
        rst_cnt_d      = rst_cnt_q;
        worker_reset_d = 1'b0;
        ruler_d        = ruler_q;
        spectrum_d     = spectrum_q;
        fail_d         = fail_q;
        b_d            = b_q;
        p_d            = p_q;
        mark_cnt_d     = mark_cnt_q;
        result_cnt_d   = result_cnt_q;
        err_cnt_d      = err_cnt_q;

        case (state_q)
            RESTART: begin
                worker_reset_d = 1'b1;
                if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
                    worker_reset_d = 1'b0;
                    rst_cnt_d      = '0;
                    state_d        = IDLE;
                end else begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                end
            end

            IDLE: begin
                if (done) begin
                    ruler_d    = natRuler;
                    spectrum_d = '0;
                    fail_d     = 1'b0;
                    b_d        = '0;
                    p_d        = '0;
                    mark_cnt_d = '0;
                    state_d    = CHECK;
                end
            end

            CHECK: begin
                if (cur_bit) begin
                    mark_cnt_d = mark_cnt_inc;
                    // Updating the spectrum per mark also catches repeated
                    // differences inside one block.
                    if ((diff & spectrum_q) != '0) begin
                        fail_d = 1'b1;
                    end else begin
                        spectrum_d = spectrum_q | diff;
                    end
                end
                if (p_q == M_WIDTH'(M)) begin
                    if (!blk[0] || (mark_cnt_inc != MC_W'(k + 1))) begin
                        fail_d = 1'b1;
                    end
                    mark_cnt_d = '0;
                    p_d        = '0;
                    if (b_q == n_iWIDTH'(n - 1)) begin
                        b_d = '0;
                        if (fail_d) begin
                            err_cnt_d      = err_cnt_q + CNT_WIDTH'(1);
                            worker_reset_d = 1'b1;
                            rst_cnt_d      = '0;
                            state_d        = RESTART;
                        end else begin
                            state_d = EMIT;
                        end
                    end else begin
                        b_d = b_q + n_iWIDTH'(1);
                    end
                end else begin
                    p_d = p_q + M_WIDTH'(1);
                end
            end

            EMIT: begin
                if (!cur_bit || outReady) begin
                    if (cur_bit && later_clear) begin
                        result_cnt_d   = result_cnt_q + CNT_WIDTH'(1);
                        worker_reset_d = 1'b1;
                        rst_cnt_d      = '0;
                        b_d            = '0;
                        p_d            = '0;
                        state_d        = RESTART;
                    end else if (p_q == M_WIDTH'(M)) begin
                        p_d = '0;
                        if (b_q == n_iWIDTH'(n - 1)) begin
                            // End of scan with nothing left to emit; a
                            // checked result always ends on outLast first.
                            b_d            = '0;
                            worker_reset_d = 1'b1;
                            rst_cnt_d      = '0;
                            state_d        = RESTART;
                        end else begin
                            b_d = b_q + n_iWIDTH'(1);
                        end
                    end else begin
                        p_d = p_q + M_WIDTH'(1);
                    end
                end
            end

            default: begin
                worker_reset_d = 1'b1;
                rst_cnt_d      = '0;
                state_d        = RESTART;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= RESTART;
            rst_cnt_q      <= '0;
            worker_reset_q <= 1'b1;
            ruler_q        <= '0;
            spectrum_q     <= '0;
            fail_q         <= 1'b0;
            b_q            <= '0;
            p_q            <= '0;
            mark_cnt_q     <= '0;
            result_cnt_q   <= '0;
            err_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            rst_cnt_q      <= rst_cnt_d;
            worker_reset_q <= worker_reset_d;
            ruler_q        <= ruler_d;
            spectrum_q     <= spectrum_d;
            fail_q         <= fail_d;
            b_q            <= b_d;
            p_q            <= p_d;
            mark_cnt_q     <= mark_cnt_d;
            result_cnt_q   <= result_cnt_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    // Stream outputs follow the scan position directly, so they stay
    // stable for as long as EMIT is stalled on outReady.
    assign workerReset = worker_reset_q;
    assign outValid    = (state_q == EMIT) && cur_bit;
    assign outMark     = outValid ? p_q : '0;
    assign outBlock    = outValid ? b_q : '0;
    assign outLast     = outValid && later_clear;
    assign resultCount = result_cnt_q;
    assign errCount    = err_cnt_q;

endmodule

// File: tb/tb_dts_result_checker.sv
module tb_dts_result_checker;

    localparam int NB  = 2;
    localparam int KM  = 2;
    localparam int MM  = 9;
    localparam int NIW = 1;
    localparam int MW  = 4;
    localparam int RC  = 4;
    localparam int CW  = 16;
    localparam int RW  = NB * (MM + 1);

    localparam logic [RW-1:0] R_VALID = {10'h211, 10'h00B};
    localparam logic [RW-1:0] R_COLL  = {10'h025, 10'h00B};
    localparam logic [RW-1:0] R_CNT   = {10'h011, 10'h00B};
    localparam logic [RW-1:0] R_ZERO  = {10'h250, 10'h00B};

    logic           clk = 1'b0;
    logic           reset;
    logic [RW-1:0]  natRuler;
    logic           done;
    logic           workerReset;
    logic           outValid;
    logic           outReady;
    logic [MW-1:0]  outMark;
    logic [NIW-1:0] outBlock;
    logic           outLast;
    logic [CW-1:0]  resultCount;
    logic [CW-1:0]  errCount;

    int vectors     = 0;
    int miscompares = 0;
    int got;

    int exp_mark [6] = '{0, 1, 3, 0, 4, 9};
    int exp_blk  [6] = '{0, 0, 0, 1, 1, 1};

    always #5 clk = ~clk;

    dts_result_checker #(
        .n(NB), .k(KM), .M(MM), .n_iWIDTH(NIW), .M_WIDTH(MW),
        .RST_CYCLES(RC), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .natRuler(natRuler), .done(done),
        .workerReset(workerReset), .outValid(outValid), .outReady(outReady),
        .outMark(outMark), .outBlock(outBlock), .outLast(outLast),
        .resultCount(resultCount), .errCount(errCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Waits for workerReset to rise, then measures how long it stays high.
    task automatic pulse_check(input string tag);
        int cyc = 0;
        int hi  = 0;
        while (!workerReset && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " rise"}, 32'(workerReset), 32'd1);
        while (workerReset && hi < 20) begin
            hi++;
            @(negedge clk);
        end
        chk({tag, " width"}, hi, RC);
    endtask

    task automatic launch(input logic [RW-1:0] r);
        natRuler = r;
        done     = 1'b1;
        @(negedge clk);
        done     = 1'b0;
    endtask

    task automatic expect_reject(input string tag, input int exp_err);
        int cyc = 0;
        bit saw = 1'b0;
        while (!workerReset && cyc < 60) begin
            if (outValid) saw = 1'b1;
            @(negedge clk);
            cyc++;
        end
        chk({tag, " latency"}, cyc, 32'd20);
        chk({tag, " no emission"}, 32'(saw), 32'd0);
        chk({tag, " errCount"}, 32'(errCount), exp_err);
        pulse_check(tag);
    endtask

    task automatic run_emit(input string tag, input int stall_at, input int stop_after,
                            output int n_got);
        int cyc = 0;
        n_got = 0;
        while (!outValid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " first valid latency"}, cyc, 32'd20);
        cyc = 0;
        while (n_got < 6 && cyc < 100) begin
            if (outValid) begin
                chk($sformatf("%s mark%0d", tag, n_got), 32'(outMark), exp_mark[n_got]);
                chk($sformatf("%s block%0d", tag, n_got), 32'(outBlock), exp_blk[n_got]);
                chk($sformatf("%s last%0d", tag, n_got), 32'(outLast), 32'(n_got == 5));
                if (n_got == stall_at) begin
                    outReady = 1'b0;
                    for (int s = 0; s < 5; s++) begin
                        @(negedge clk);
                        chk($sformatf("%s hold valid c%0d", tag, s), 32'(outValid), 32'd1);
                        chk($sformatf("%s hold mark c%0d", tag, s), 32'(outMark), exp_mark[n_got]);
                        chk($sformatf("%s hold block c%0d", tag, s), 32'(outBlock), exp_blk[n_got]);
                    end
                    outReady = 1'b1;
                end
                n_got++;
                if (n_got == stop_after) begin
                    @(negedge clk);
                    outReady = 1'b0;
                    cyc = 0;
                    while (!outValid && cyc < 20) begin
                        @(negedge clk);
                        cyc++;
                    end
                    return;
                end
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, " marks emitted"}, n_got, 32'd6);
    endtask

    initial begin
        reset    = 1'b1;
        done     = 1'b0;
        outReady = 1'b1;
        natRuler = '0;
        repeat (3) @(negedge clk);

        chk("reset workerReset", 32'(workerReset), 32'd1);
        chk("reset outValid", 32'(outValid), 32'd0);
        chk("reset outMark", 32'(outMark), 32'd0);
        chk("reset outBlock", 32'(outBlock), 32'd0);
        chk("reset outLast", 32'(outLast), 32'd0);
        chk("reset resultCount", 32'(resultCount), 32'd0);
        chk("reset errCount", 32'(errCount), 32'd0);

        reset = 1'b0;
        for (int i = 0; i < RC; i++) begin
            chk($sformatf("initial restart high c%0d", i), 32'(workerReset), 32'd1);
            @(negedge clk);
        end
        chk("initial restart low", 32'(workerReset), 32'd0);
        chk("idle outValid", 32'(outValid), 32'd0);

        // Legal result, consumer always ready.
        launch(R_VALID);
        run_emit("valid", -1, -1, got);
        chk("valid outValid after last", 32'(outValid), 32'd0);
        chk("valid resultCount", 32'(resultCount), 32'd1);
        chk("valid errCount", 32'(errCount), 32'd0);
        pulse_check("valid restart");

        // Rejected results; errCount accumulates across the three.
        launch(R_COLL);
        expect_reject("collision", 1);
        launch(R_CNT);
        expect_reject("mark count", 2);
        launch(R_ZERO);
        expect_reject("zero mark", 3);
        chk("rejects resultCount", 32'(resultCount), 32'd1);

        // Legal result with a 5-cycle stall on (3,0).
        launch(R_VALID);
        run_emit("backpressure", 2, -1, got);
        chk("backpressure resultCount", 32'(resultCount), 32'd2);
        pulse_check("backpressure restart");

        // Reset while (3,0) is being offered, after two marks were accepted.
        launch(R_VALID);
        run_emit("abort", -1, 2, got);
        chk("abort accepted", got, 32'd2);
        chk("abort pre valid", 32'(outValid), 32'd1);
        chk("abort pre mark", 32'(outMark), 32'd3);
        reset = 1'b1;
        #1;
        chk("abort outValid", 32'(outValid), 32'd0);
        chk("abort outMark", 32'(outMark), 32'd0);
        chk("abort outBlock", 32'(outBlock), 32'd0);
        chk("abort outLast", 32'(outLast), 32'd0);
        chk("abort resultCount", 32'(resultCount), 32'd0);
        chk("abort errCount", 32'(errCount), 32'd0);
        chk("abort workerReset", 32'(workerReset), 32'd1);
        @(negedge clk);
        outReady = 1'b1;
        reset    = 1'b0;
        pulse_check("abort restart");
        chk("abort final resultCount", 32'(resultCount), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
